run_sequencer: RTL and testbench

RUN_SEQUENCER -- requirements
Module: run_sequencer

---
 rtl/run_sequencer_pkg.sv | 15 +
 rtl/run_sequencer_if.sv | 29 ++
 rtl/run_sequencer_sat_counter.sv | 28 ++
 rtl/run_sequencer.sv | 110 +++++++++++
 tb/tb_run_sequencer.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/run_sequencer_pkg.sv
// Shared types and widths for the problem run sequencer.
package run_sequencer_pkg;

  localparam int CNT_W  = 16;
  localparam int PROB_W = 2;

  typedef logic [2:0] state_t;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LAUNCH = 3'd1;
  localparam logic [2:0] ST_RUN    = 3'd2;
  localparam logic [2:0] ST_RECORD = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

endpackage

// File: rtl/run_sequencer_if.sv
// Host/CPU-facing signal bundle of the run sequencer; master is the sequencer side.
interface run_sequencer_if;
  import run_sequencer_pkg::*;

  logic              go;
  logic              cpu_halt;
  logic              cpu_start;
  logic [PROB_W-1:0] cpu_problem;
  logic              busy;
  logic              done;
  logic              result_valid;
  logic [PROB_W-1:0] result_problem;
  logic [CNT_W-1:0]  result_cycles;
  logic              result_timeout;
  logic [3:0]        timeout_mask;

  modport master (
    input  go, cpu_halt,
    output cpu_start, cpu_problem, busy, done,
           result_valid, result_problem, result_cycles, result_timeout, timeout_mask
  );

  modport slave (
    output go, cpu_halt,
    input  cpu_start, cpu_problem, busy, done,
           result_valid, result_problem, result_cycles, result_timeout, timeout_mask
  );

endinterface

// File: rtl/run_sequencer_sat_counter.sv
// Up-counter with synchronous clear (dominant over enable) that sticks at all-ones.
module sat_counter
  import run_sequencer_pkg::*;
(
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (count_q != '1)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/run_sequencer.sv
// Runs problems 0..NUM_PROBLEMS-1 on a CPU in turn: hold it in start for a fixed time,
// let it run until halt or timeout, and publish one result per problem.
module run_sequencer
  import run_sequencer_pkg::*;
#(
  parameter int NUM_PROBLEMS   = 3,
  parameter int START_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic            clk,
  input  logic            start,
  run_sequencer_if.master bus
);

  localparam logic [CNT_W-1:0]  LAUNCH_LAST = CNT_W'(START_CYCLES - 1);
  localparam logic [CNT_W-1:0]  TIMEOUT_LIM = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [PROB_W-1:0] LAST_PROB   = PROB_W'(NUM_PROBLEMS - 1);

  state_t            state_d, state_q;
  logic [PROB_W-1:0] prob_d, prob_q;
  logic [PROB_W-1:0] res_prob_d, res_prob_q;
  logic [CNT_W-1:0]  res_cycles_d, res_cycles_q;
  logic              res_to_d, res_to_q;
  logic [3:0]        tmask_d, tmask_q;
  logic              enter_run;
  logic [CNT_W-1:0]  launch_cnt, run_cnt;
  logic              launch_clr, run_clr;

  // Run counter is pre-armed on the LAUNCH->RUN edge so it reads 1 in the first RUN cycle.
  assign launch_clr = start || (state_q != ST_LAUNCH);
  assign run_clr    = start || ((state_q != ST_RUN) && !enter_run);

  sat_counter u_launch_cnt (.clk(clk), .clr(launch_clr), .en(1'b1), .count(launch_cnt));
  sat_counter u_run_cnt    (.clk(clk), .clr(run_clr),    .en(1'b1), .count(run_cnt));

  always_comb begin
    state_d      = state_q;
    prob_d       = prob_q;
    res_prob_d   = res_prob_q;
    res_cycles_d = res_cycles_q;
    res_to_d     = res_to_q;
    tmask_d      = tmask_q;
    enter_run    = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.go) begin
          state_d = ST_LAUNCH;
          prob_d  = '0;
          tmask_d = '0;
        end
      end
      ST_LAUNCH: begin
        if (launch_cnt == LAUNCH_LAST) begin
          state_d   = ST_RUN;
          enter_run = 1'b1;
        end
      end
      ST_RUN: begin
        // Halt beats a simultaneous timeout.
        if (bus.cpu_halt || (run_cnt == TIMEOUT_LIM)) begin
          state_d      = ST_RECORD;
          res_prob_d   = prob_q;
          res_cycles_d = run_cnt;
          res_to_d     = !bus.cpu_halt;
          if (!bus.cpu_halt) begin
            tmask_d[prob_q] = 1'b1;
          end
        end
      end
      ST_RECORD: begin
        if (prob_q == LAST_PROB) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_LAUNCH;
          prob_d  = prob_q + PROB_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (start) begin
      state_q      <= ST_IDLE;
      prob_q       <= '0;
      res_prob_q   <= '0;
      res_cycles_q <= '0;
      res_to_q     <= 1'b0;
      tmask_q      <= '0;
    end else begin
      state_q      <= state_d;
      prob_q       <= prob_d;
      res_prob_q   <= res_prob_d;
      res_cycles_q <= res_cycles_d;
      res_to_q     <= res_to_d;
      tmask_q      <= tmask_d;
    end
  end

  assign bus.cpu_start      = (state_q != ST_RUN);
  assign bus.cpu_problem    = prob_q;
  assign bus.busy           = (state_q == ST_LAUNCH) || (state_q == ST_RUN) || (state_q == ST_RECORD);
  assign bus.done           = (state_q == ST_DONE);
  assign bus.result_valid   = (state_q == ST_RECORD);
  assign bus.result_problem = res_prob_q;
  assign bus.result_cycles  = res_cycles_q;
  assign bus.result_timeout = res_to_q;
  assign bus.timeout_mask   = tmask_q;

endmodule

// File: tb/tb_run_sequencer.sv
// Directed and randomized sequences checked against a per-problem halt/timeout model.
module tb_run_sequencer;
  import run_sequencer_pkg::*;

  localparam int NP = 3;
  localparam int SC = 2;
  localparam int TO = 20;

  logic clk = 1'b0;
  logic start;
  int   n_assert = 0;
  int   n_fail   = 0;
  bit   aborted;

  run_sequencer_if bus();

  run_sequencer #(
    .NUM_PROBLEMS  (NP),
    .START_CYCLES  (SC),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk  (clk),
    .start(start),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_cleared(input string tag);
    chk({tag, "_cpu_start"},      bus.cpu_start, 1);
    chk({tag, "_cpu_problem"},    bus.cpu_problem, 0);
    chk({tag, "_busy"},           bus.busy, 0);
    chk({tag, "_done"},           bus.done, 0);
    chk({tag, "_result_valid"},   bus.result_valid, 0);
    chk({tag, "_result_problem"}, bus.result_problem, 0);
    chk({tag, "_result_cycles"},  bus.result_cycles, 0);
    chk({tag, "_result_timeout"}, bus.result_timeout, 0);
    chk({tag, "_timeout_mask"},   bus.timeout_mask, 0);
  endtask

  // hN: RUN cycle (1-based) on which cpu_halt is raised for problem N; 0 or >TO means never.
  task automatic run_seq(input int h0, input int h1, input int h2, input bit launch_halt,
                         input bit go_in_run, input int abort_prob, output bit was_aborted);
    int         ha[3];
    int         nl;
    int         rc;
    int         exp_cyc;
    int         prev_cyc;
    bit         exp_to;
    logic [3:0] mask_m;
    ha[0] = h0; ha[1] = h1; ha[2] = h2;
    mask_m      = '0;
    prev_cyc    = 0;
    was_aborted = 1'b0;
    bus.go = 1'b1;
    step();
    bus.go = 1'b0;
    for (int p = 0; p < NP; p++) begin
      nl = 0;
      while (bus.cpu_start && bus.busy && nl < 50) begin
        if (nl == 0) begin
          chk("launch_problem", bus.cpu_problem, p);
          if (p == 0) begin
            chk("launch_mask_cleared", bus.timeout_mask, 0);
            chk("launch_done_cleared", bus.done, 0);
          end else begin
            chk("result_hold", bus.result_cycles, prev_cyc);
          end
        end
        bus.cpu_halt = launch_halt;
        nl++;
        step();
      end
      chk("launch_len", nl, SC);
      rc = 0;
      while (!bus.cpu_start && rc < 200) begin
        rc++;
        if (p == abort_prob && rc == 5) begin
          bus.cpu_halt = 1'b0;
          start = 1'b1;
          step();
          start = 1'b0;
          check_idle_cleared("abort");
          step();
          chk("abort_no_pulse", bus.result_valid, 0);
          chk("abort_idle_busy", bus.busy, 0);
          was_aborted = 1'b1;
          return;
        end
        bus.cpu_halt = (rc == ha[p]);
        bus.go       = go_in_run && (rc == 3);
        step();
      end
      bus.cpu_halt = 1'b0;
      bus.go       = 1'b0;
      exp_to  = !(ha[p] >= 1 && ha[p] <= TO);
      exp_cyc = exp_to ? TO : ha[p];
      if (exp_to) mask_m[p] = 1'b1;
      chk("run_len",        rc, exp_cyc);
      chk("record_valid",   bus.result_valid, 1);
      chk("record_cpu_start", bus.cpu_start, 1);
      chk("record_problem", bus.result_problem, p);
      chk("record_cycles",  bus.result_cycles, exp_cyc);
      chk("record_timeout", bus.result_timeout, exp_to);
      chk("record_mask",    bus.timeout_mask, mask_m);
      prev_cyc = exp_cyc;
      step();
      chk("pulse_one_cycle", bus.result_valid, 0);
    end
    chk("end_done",      bus.done, 1);
    chk("end_busy",      bus.busy, 0);
    chk("end_cpu_start", bus.cpu_start, 1);
    chk("end_mask",      bus.timeout_mask, mask_m);
  endtask

  initial begin
    start        = 1'b1;
    bus.go       = 1'b0;
    bus.cpu_halt = 1'b0;
    repeat (3) step();
    bus.go       = 1'b1;
    bus.cpu_halt = 1'b1;
    step();
    check_idle_cleared("reset");
    bus.go       = 1'b0;
    bus.cpu_halt = 1'b0;
    start        = 1'b0;
    step();
    chk("idle_after_reset_busy", bus.busy, 0);
    chk("idle_after_reset_cpu_start", bus.cpu_start, 1);

    run_seq(10, 10, 10, 1'b0, 1'b0, -1, aborted);
    repeat (3) step();
    chk("done_held", bus.done, 1);

    run_seq(0, 0, 0, 1'b1, 1'b0, -1, aborted);
    run_seq(20, 20, 20, 1'b0, 1'b1, -1, aborted);
    run_seq(10, 7, 10, 1'b0, 1'b0, 1, aborted);
    chk("abort_flag", aborted, 1);
    run_seq(1, 20, 21, 1'b1, 1'b1, -1, aborted);

    for (int i = 0; i < 6; i++) begin
      run_seq(int'($urandom_range(0, 25)), int'($urandom_range(0, 25)), int'($urandom_range(0, 25)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1, aborted);
      repeat (int'($urandom_range(0, 3))) step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
